// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder cell reused across WIDTH bit positions, LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf and its capture flop.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_cout;
  logic             w_x;
  logic             w_y;
  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

  // The single shared full-adder cell.
  assign w_x      = r_opA[0];
  assign w_y      = r_opB[0];
  assign w_s      = w_x ^ w_y ^ r_carry;
  assign w_co     = (w_x & w_y) | ((w_x ^ w_y) & r_carry);
  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = RUN;
      RUN:     if (w_last) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Sum is shifted in from the MSB side so bit i settles in sum[i] after WIDTH shifts;
  // it is left untouched on the accepting edge so the previous result stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opA   <= '0;
      r_opB   <= '0;
      r_sum   <= '0;
      r_count <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_opA   <= a;
      r_opB   <= b;
      r_carry <= cin;
      r_count <= '0;
    end else if (r_state == RUN) begin
      r_opA   <= r_opA >> 1;
      r_opB   <= r_opB >> 1;
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_co;
      r_count <= r_count + 1'b1;
      if (w_last) begin
        r_cout <= w_co;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_carryMsb;

  // Carry into the MSB, captured alongside cout so ovf holds with the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_carryMsb <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_carryMsb <= r_carry;
    end
  end

  assign ovf = r_carryMsb ^ r_cout;
`endif

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: WIDTH=8 directed/random adds and a WIDTH=2 sweep,
// checked against plain integer addition.
module tb_serial_add_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       cin2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
  logic       ovf2;
`endif

  int checks = 0;
  int errors = 0;

  serial_add_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_add_seq #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge; all driving and sampling happens there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 add with full timing checks; returns with the DUT idle again.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input string name);
    logic [8:0] expSum;
    logic       expOvf;
    bit         seen;
    expSum = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
    expOvf = (ta[7] == tb[7]) && (expSum[7] != ta[7]);
    start = 1'b1; a = ta; b = tb; cin = tc;
    step();
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("[TB] FAIL %s_busy_at_start busy=%b done=%b required busy=1 done=0", name, busy, done);
    seen = 0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      step();
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      if (done === 1'b1) begin
        seen = 1;
        checks++;
        if (k != 8) begin errors++; $display("[TB] FAIL %s_latency got=%0d required=8", name, k); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_in_done got=%b required=0", name, busy); end
        checks++;
        if (sum !== expSum[7:0]) begin
          errors++; $display("[TB] FAIL %s_sum got=%h required=%h", name, sum, expSum[7:0]);
        end
        checks++;
        if (cout !== expSum[8]) begin
          errors++; $display("[TB] FAIL %s_cout got=%b required=%b", name, cout, expSum[8]);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf !== expOvf) begin errors++; $display("[TB] FAIL %s_ovf got=%b required=%b", name, ovf, expOvf); end
`endif
      end else if (k < 8) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy_run cycle=%0d got=%b required=1", name, k, busy); end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL %s_done_timeout got=no_done required=done_at_8", name);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== expSum[7:0] || cout !== expSum[8]) begin
      errors++;
      $display("[TB] FAIL %s_idle_hold done=%b busy=%b sum=%h cout=%b required 0 0 %h %b",
               name, done, busy, sum, cout, expSum[7:0], expSum[8]);
    end
    if (expOvf === 1'bx) $display("[TB] unreachable");
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    a = '0; b = '0; cin = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values busy=%b done=%b sum=%h cout=%b required 0 0 00 0", busy, done, sum, cout);
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got=%b required=0", ovf); end
`endif
  endtask

  task automatic test_directed();
    run8(8'h3C, 8'h45, 1'b0, "add_3c_45");
    run8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run8(8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");
    run8(8'h80, 8'h80, 1'b0, "add_80_80");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_start_held();
    int doneCount;
    logic [7:0] doneSum;
    doneCount = 0; doneSum = 8'h00;
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    step();
    a = 8'hAA; b = 8'hAA; cin = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (done === 1'b1) begin doneCount++; doneSum = sum; end
    end
    start = 1'b0;
    checks++;
    if (doneCount != 1) begin errors++; $display("[TB] FAIL held_done_count got=%0d required=1", doneCount); end
    checks++;
    if (doneSum !== 8'h02) begin errors++; $display("[TB] FAIL held_sum got=%h required=02", doneSum); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL held_no_restart_in_done got=%b required=0", busy); end
    step();
  endtask

  task automatic test_reset_mid_run();
    bit spurious;
    start = 1'b1; a = 8'h5A; b = 8'h33; cin = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_reset busy=%b done=%b sum=%h cout=%b required 0 0 00 0", busy, done, sum, cout);
    end
    spurious = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) spurious = 1;
    end
    checks++;
    if (spurious) begin errors++; $display("[TB] FAIL midrun_no_done got=activity required=idle"); end
    run8(8'h5A, 8'h33, 1'b1, "after_reset");
  endtask

  task automatic test_reset_start_collision();
    rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
    step();
    rst = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_start_collision busy=%b required=0", busy); end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_start_stays_idle busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_width2_sweep();
    logic [2:0] expVal;
    logic [4:0] v;
    int lat;
    for (int n = 0; n < 32; n++) begin
      v = 5'(n);
      expVal = {1'b0, v[4:3]} + {1'b0, v[2:1]} + {2'b00, v[0]};
      start2 = 1'b1; a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0];
      step();
      start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
      lat = 0;
      for (int k = 1; k <= 6 && lat == 0; k++) begin
        step();
        if (done2 === 1'b1) lat = k;
      end
      checks++;
      if (lat != 2) begin errors++; $display("[TB] FAIL w2_latency v=%0d got=%0d required=2", n, lat); end
      checks++;
      if ({cout2, sum2} !== expVal) begin
        errors++; $display("[TB] FAIL w2_result v=%0d got=%b required=%b", n, {cout2, sum2}, expVal);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_reset_mid_run();
    test_reset_start_collision();
    test_width2_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
